// File: rtl/tt_pkg.sv
// -----------------------------------------------------------------------------
// tt_pkg
// Shared types and helpers for the truth-table term extractor.
//   state_t        : extractor FSM states (IDLE, SCAN, DONE)
//   N_VARS_DEFAULT : default number of input variables
//   tt_w(n)        : truth-table width for n variables (1 << n)
// -----------------------------------------------------------------------------
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_VARS_DEFAULT = 4;

  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_upper_ones_detect.sv
// -----------------------------------------------------------------------------
// tt_upper_ones_detect
// Combinational: reports whether every truth-table bit strictly above row idx
// is one, i.e. no further term exists above idx. True at idx = TT_W-1.
// Ports:
//   tt         in  TT_W    truth table (already polarity-adjusted by caller)
//   idx        in  N_VARS  current row index
//   upper_ones out 1       all bits above idx are one
// -----------------------------------------------------------------------------
module tt_upper_ones_detect
  import tt_pkg::*;
#(
  parameter int N_VARS = N_VARS_DEFAULT
) (
  input  logic [tt_w(N_VARS)-1:0] tt,
  input  logic [N_VARS-1:0]       idx,
  output logic                    upper_ones
);

  localparam int TT_W = tt_w(N_VARS);

  // Mask of rows strictly above idx: all ones shifted left by idx+1.
  // At idx = TT_W-1 the mask is empty, so the result is trivially true.
  logic [TT_W-1:0] above_mask;
  logic [TT_W-1:0] bit_ok;

  assign above_mask = ({TT_W{1'b1}} << idx) << 1;

  for (genvar gi = 0; gi < TT_W; gi++) begin : g_bit_ok
    assign bit_ok[gi] = tt[gi] | ~above_mask[gi];
  end

  assign upper_ones = &bit_ok;

endmodule

// File: rtl/truth_table_pos_extractor.sv
// -----------------------------------------------------------------------------
// truth_table_pos_extractor
// Loads a TT_W-bit truth table on start and streams out the row indices where
// F=0 (maxterms, canonical POS list) one per handshake, lowest row first.
// Optional build macro MINTERM_MODE_EN adds a sop_mode input, latched at start;
// when latched high the rows where F=1 (minterms) are emitted instead.
// Ports:
//   clk        in  1         rising-edge clock
//   reset_n    in  1         asynchronous active-low reset
//   start      in  1         load tt_in and begin a scan (IDLE only)
//   tt_in      in  TT_W      truth table, bit i = F(row i)
//   sop_mode   in  1         (MINTERM_MODE_EN only) emit minterms when high
//   busy       out 1         high in SCAN and DONE
//   term_valid out 1         term_idx holds a term
//   term_ready in  1         consumer accepts term on valid & ready
//   term_idx   out N_VARS    term row index
//   term_last  out 1         no further term above term_idx
//   done       out 1         one-cycle pulse at end of scan
//   term_count out N_VARS+1  terms accepted in current/last scan
// -----------------------------------------------------------------------------
module truth_table_pos_extractor
  import tt_pkg::*;
#(
  parameter int N_VARS = N_VARS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [tt_w(N_VARS)-1:0] tt_in,
`ifdef MINTERM_MODE_EN
  input  logic                    sop_mode,
`endif
  output logic                    busy,
  output logic                    term_valid,
  input  logic                    term_ready,
  output logic [N_VARS-1:0]       term_idx,
  output logic                    term_last,
  output logic                    done,
  output logic [N_VARS:0]         term_count
);

  localparam int TT_W = tt_w(N_VARS);

  state_t              state_reg;
  logic [N_VARS-1:0]   idx_reg;
  logic [TT_W-1:0]     tt_reg;
  logic [N_VARS:0]     term_count_reg;

  // eff_tt is the table in "emit where zero" polarity, so the rest of the
  // datapath is identical for maxterm and minterm extraction.
  logic [TT_W-1:0]     eff_tt;

`ifdef MINTERM_MODE_EN
  logic sop_mode_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sop_mode_reg <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      sop_mode_reg <= sop_mode;
    end
  end

  assign eff_tt = sop_mode_reg ? ~tt_reg : tt_reg;
`else
  assign eff_tt = tt_reg;
`endif

  logic row_is_term;
  logic idx_at_end;
  logic advance;
  logic upper_ones;

  assign row_is_term = ~eff_tt[idx_reg];
  assign idx_at_end  = (idx_reg == N_VARS'(TT_W - 1));
  // A row is consumed either by skipping it (not a term) or by a handshake.
  assign advance     = (state_reg == SCAN) && (!row_is_term || term_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      tt_reg         <= '0;
      term_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            tt_reg         <= tt_in;
            idx_reg        <= '0;
            term_count_reg <= '0;
            state_reg      <= SCAN;
          end
        end
        SCAN: begin
          if (row_is_term && term_ready) begin
            term_count_reg <= term_count_reg + (N_VARS + 1)'(1);
          end
          if (advance) begin
            // idx never wraps: the last row hands over to DONE instead.
            if (idx_at_end) begin
              state_reg <= DONE;
            end else begin
              idx_reg <= idx_reg + N_VARS'(1);
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  tt_upper_ones_detect #(
    .N_VARS (N_VARS)
  ) u_upper_ones (
    .tt         (eff_tt),
    .idx        (idx_reg),
    .upper_ones (upper_ones)
  );

  assign busy       = (state_reg == SCAN) || (state_reg == DONE);
  assign done       = (state_reg == DONE);
  assign term_valid = (state_reg == SCAN) && row_is_term;
  assign term_idx   = term_valid ? idx_reg : '0;
  assign term_last  = term_valid && upper_ones;
  assign term_count = term_count_reg;

endmodule

// File: tb/tb_truth_table_pos_extractor.sv
// -----------------------------------------------------------------------------
// tb_truth_table_pos_extractor
// Directed bench for truth_table_pos_extractor: a 3-variable instance for the
// 8-row case and a 4-variable instance for the 16-row cases.
// -----------------------------------------------------------------------------
module tb_truth_table_pos_extractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // 3-variable instance
  logic       start3, ready3;
  logic [7:0] tt3;
  logic       busy3, valid3, last3, done3;
  logic [2:0] idx3;
  logic [3:0] count3;

  // 4-variable instance
  logic        start4, ready4;
  logic [15:0] tt4;
  logic        busy4, valid4, last4, done4;
  logic [3:0]  idx4;
  logic [4:0]  count4;

  truth_table_pos_extractor #(.N_VARS(3)) dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start3),
    .tt_in      (tt3),
`ifdef MINTERM_MODE_EN
    .sop_mode   (1'b0),
`endif
    .busy       (busy3),
    .term_valid (valid3),
    .term_ready (ready3),
    .term_idx   (idx3),
    .term_last  (last3),
    .done       (done3),
    .term_count (count3)
  );

  truth_table_pos_extractor #(.N_VARS(4)) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start4),
    .tt_in      (tt4),
`ifdef MINTERM_MODE_EN
    .sop_mode   (1'b0),
`endif
    .busy       (busy4),
    .term_valid (valid4),
    .term_ready (ready4),
    .term_idx   (idx4),
    .term_last  (last4),
    .done       (done4),
    .term_count (count4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Results of the most recent scan4 run.
  int q4[$];
  int cyc4, last_n4, last_at4, count_at_done4, valid_seen4;
  int stall_seen4, stall_bad4, busy_bad4, post_done_bad4;

  // Runs one scan on the 4-variable instance. The first stall_cycles cycles
  // in which a term is offered are held with term_ready low. When pulse_mid
  // is set, a second start with a different table is pulsed mid-scan.
  task automatic scan4(input logic [15:0] tt, input int stall_cycles,
                       input bit pulse_mid);
    int stall_left;
    int stall_idx;
    q4.delete();
    cyc4 = -1; last_n4 = 0; last_at4 = -1; count_at_done4 = -1;
    valid_seen4 = 0; stall_seen4 = 0; stall_bad4 = 0; busy_bad4 = 0;
    post_done_bad4 = 0;
    stall_left = stall_cycles;
    stall_idx  = -1;
    @(negedge clk);
    tt4 = tt; start4 = 1'b1; ready4 = (stall_left == 0);
    @(negedge clk);
    start4 = 1'b0;
    for (int e = 0; e < 200; e++) begin
      if (done4) begin
        cyc4 = e + 1;
        count_at_done4 = int'(count4);
        break;
      end
      if (!busy4) busy_bad4++;
      ready4 = (stall_left == 0);
      if (valid4) valid_seen4++;
      if (valid4 && !ready4) begin
        stall_seen4++;
        if (stall_idx < 0) stall_idx = int'(idx4);
        else if (int'(idx4) != stall_idx || !last4) stall_bad4++;
        stall_left--;
      end
      if (valid4 && ready4) begin
        q4.push_back(int'(idx4));
        if (last4) begin
          last_n4++;
          last_at4 = int'(idx4);
        end
      end
      if (pulse_mid && e == 3) begin
        start4 = 1'b1;
        tt4 = 16'h0000;
      end else begin
        start4 = 1'b0;
      end
      @(negedge clk);
    end
    start4 = 1'b0;
    ready4 = 1'b0;
    @(negedge clk);
    if (done4 || busy4) post_done_bad4 = 1;
  endtask

  int terms3[$];
  int cyc3, last_n3, last_at3, count_at_done3;
  int exp1[4]  = '{0, 3, 4, 6};
  int exp5[8]  = '{0, 1, 2, 3, 8, 9, 10, 11};
  int exp6[8]  = '{4, 5, 6, 7, 12, 13, 14, 15};
  int accepted;
  int done_during_reset;

  initial begin
    reset_n = 1'b0;
    start3 = 1'b0; ready3 = 1'b0; tt3 = 8'h00;
    start4 = 1'b0; ready4 = 1'b0; tt4 = 16'h0000;

    // ---- reset state ----
    @(negedge clk); @(negedge clk);
    check("rst_busy4",  32'(busy4),  0);
    check("rst_valid4", 32'(valid4), 0);
    check("rst_done4",  32'(done4),  0);
    check("rst_count4", 32'(count4), 0);
    check("rst_idx4",   32'(idx4),   0);
    check("rst_last4",  32'(last4),  0);
    check("rst_busy3",  32'(busy3),  0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_busy4", 32'(busy4), 0);

    // ---- test 1: N_VARS=3, tt=A6, ready tied high ----
    tt3 = 8'hA6; start3 = 1'b1; ready3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc3 = -1; last_n3 = 0; last_at3 = -1; count_at_done3 = -1;
    for (int e = 0; e < 100; e++) begin
      if (done3) begin
        cyc3 = e + 1;
        count_at_done3 = int'(count3);
        break;
      end
      if (valid3 && ready3) begin
        terms3.push_back(int'(idx3));
        if (last3) begin
          last_n3++;
          last_at3 = int'(idx3);
        end
      end
      @(negedge clk);
    end
    ready3 = 1'b0;
    check("t1_nterms", terms3.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_term%0d", i),
            (i < terms3.size()) ? terms3[i] : -1, exp1[i]);
    check("t1_last_n",  last_n3, 1);
    check("t1_last_at", last_at3, 6);
    check("t1_count",   count_at_done3, 4);
    check("t1_latency", cyc3, 9);

    // ---- test 2: all ones, no terms ----
    scan4(16'hFFFF, 0, 1'b0);
    check("t2_valid_seen", valid_seen4, 0);
    check("t2_latency",    cyc4, 17);
    check("t2_count",      count_at_done4, 0);
    check("t2_post_done",  post_done_bad4, 0);
    check("t2_busy",       busy_bad4, 0);

    // ---- test 3: all zeros, 16 consecutive terms ----
    scan4(16'h0000, 0, 1'b0);
    check("t3_nterms", q4.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("t3_term%0d", i), (i < q4.size()) ? q4[i] : -1, i);
    check("t3_last_n",  last_n4, 1);
    check("t3_last_at", last_at4, 15);
    check("t3_count",   count_at_done4, 16);
    check("t3_latency", cyc4, 17);

    // ---- test 4: FFFE with ready held low for 5 cycles ----
    scan4(16'hFFFE, 5, 1'b0);
    check("t4_stall_cycles", stall_seen4, 5);
    check("t4_stall_stable", stall_bad4, 0);
    check("t4_nterms",  q4.size(), 1);
    check("t4_term0",   (q4.size() > 0) ? q4[0] : -1, 0);
    check("t4_last_at", last_at4, 0);
    check("t4_count",   count_at_done4, 1);
    check("t4_latency", cyc4, 22);

    // ---- test 5: start pulsed mid-scan with another table ----
    scan4(16'hF0F0, 0, 1'b1);
    check("t5_nterms", q4.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t5_term%0d", i),
            (i < q4.size()) ? q4[i] : -1, exp5[i]);
    check("t5_last_at", last_at4, 11);
    check("t5_count",   count_at_done4, 8);

    // ---- test 6: reset mid-scan, then rescan ----
    @(negedge clk);
    tt4 = 16'h0F0F; start4 = 1'b1; ready4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    accepted = 0;
    for (int e = 0; e < 40 && accepted < 2; e++) begin
      if (valid4 && ready4) accepted++;
      @(negedge clk);
    end
    check("t6_accepted",     accepted, 2);
    check("t6_count_before", 32'(count4), 2);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(valid4), 0);
    check("t6_rst_busy",  32'(busy4),  0);
    check("t6_rst_count", 32'(count4), 0);
    check("t6_rst_idx",   32'(idx4),   0);
    done_during_reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done4) done_during_reset++;
    end
    reset_n = 1'b1;
    @(negedge clk);
    if (done4) done_during_reset++;
    check("t6_no_done", done_during_reset, 0);
    scan4(16'h0F0F, 0, 1'b0);
    check("t6_nterms", q4.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t6_term%0d", i),
            (i < q4.size()) ? q4[i] : -1, exp6[i]);
    check("t6_last_at", last_at4, 15);
    check("t6_count",   count_at_done4, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
